// File: rtl/mem_port_arbiter_if.sv
// Request/response handshakes of the fetch and load/store requesters plus the unified memory port.
// No timing of its own; pure signal bundle.
// Requesters hold req until gnt; the memory side never stalls.
interface mem_port_arbiter_if;
  // instruction fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // load/store requester
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [2:0]  ls_funct3;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  // memory array port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  // status
  logic        busy;

  // arbiter side
  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_funct3,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output busy
  );

  // requesters and memory side
  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_funct3,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between fetch and load/store, with RV32I lane steering.
// Grant at T: mem_en T+1..T+MEM_LAT, rvalid at T+MEM_LAT+1; rejected LS accesses respond at T+1.
// Grants only in IDLE; requests hold until granted, responses cannot be stalled.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  // access captured on the grant edge
  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        err;
  } req_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  owner_t      last_owner;
  req_t        cur;
  logic        grant_if, grant_ls;
  logic        ls_bad;
  logic [3:0]  st_strb;
  logic [31:0] st_dat;
  logic [31:0] lane;
  logic [31:0] load_dat;
  logic [31:0] if_rdata_q, ls_rdata_q;

  // reject misaligned accesses, unknown funct3 and stores with an unsigned width code
  always_comb begin
    ls_bad = 1'b0;
    case (bus.ls_funct3)
      3'b000:  ls_bad = 1'b0;
      3'b001:  ls_bad = bus.ls_addr[0];
      3'b010:  ls_bad = |bus.ls_addr[1:0];
      3'b100:  ls_bad = bus.ls_we;
      3'b101:  ls_bad = bus.ls_we | bus.ls_addr[0];
      default: ls_bad = 1'b1;
    endcase
  end

  // replicate store data across lanes and place the strobes on the addressed bytes
  always_comb begin
    st_strb = 4'b1111;
    st_dat  = cur.wdata;
    case (cur.funct3)
      3'b000: begin
        st_strb = 4'b0001 << cur.addr[1:0];
        st_dat  = {4{cur.wdata[7:0]}};
      end
      3'b001: begin
        st_strb = 4'b0011 << cur.addr[1:0];
        st_dat  = {2{cur.wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_dat  = cur.wdata;
      end
    endcase
  end

  // shift the addressed lane down and sign/zero extend it
  always_comb begin
    lane     = bus.mem_rdata >> {cur.addr[1:0], 3'b000};
    load_dat = bus.mem_rdata;
    case (cur.funct3)
      3'b000:  load_dat = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_dat = {24'h0, lane[7:0]};
      3'b001:  load_dat = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_dat = {16'h0, lane[15:0]};
      default: load_dat = bus.mem_rdata;
    endcase
  end

  // arbitration and next state; a tie goes to whoever was not served last
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (bus.ls_req && (!bus.if_req || last_owner == OWN_IF)) begin
            grant_ls = 1'b1;
          end else if (bus.if_req) begin
            grant_if = 1'b1;
          end
          if (grant_ls) begin
            state_nxt = ls_bad ? RESP : ACCESS;
          end else if (grant_if) begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt == LAST_CNT) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // latch the granted access, run the latency counter, capture response data
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      last_owner <= OWN_IF;
      cur        <= '0;
      if_rdata_q <= 32'h0;
      ls_rdata_q <= 32'h0;
    end else begin
      if (grant_ls || grant_if) begin
        cur.owner  <= grant_ls ? OWN_LS : OWN_IF;
        cur.we     <= grant_ls & bus.ls_we;
        cur.addr   <= grant_ls ? bus.ls_addr : bus.if_addr;
        cur.wdata  <= grant_ls ? bus.ls_wdata : 32'h0;
        cur.funct3 <= grant_ls ? bus.ls_funct3 : 3'b010;
        cur.err    <= grant_ls & ls_bad;
        last_owner <= grant_ls ? OWN_LS : OWN_IF;
        cnt        <= 4'd0;
        // a rejected access responds next cycle with zero data
        if (grant_ls && ls_bad) begin
          ls_rdata_q <= 32'h0;
        end
      end
      if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
        if (cnt == LAST_CNT) begin
          if (cur.owner == OWN_LS) begin
            ls_rdata_q <= cur.we ? 32'h0 : load_dat;
          end else begin
            if_rdata_q <= bus.mem_rdata;
          end
        end
      end
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.ls_gnt    = grant_ls;
  assign bus.if_rvalid = (state == RESP) && (cur.owner == OWN_IF);
  assign bus.ls_rvalid = (state == RESP) && (cur.owner == OWN_LS);
  assign bus.ls_err    = bus.ls_rvalid & cur.err;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_en    = (state == ACCESS);
  assign bus.mem_we    = bus.mem_en & cur.we;
  assign bus.mem_addr  = bus.mem_en ? {cur.addr[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata = bus.mem_we ? st_dat : 32'h0;
  assign bus.mem_wstrb = bus.mem_we ? st_strb : 4'b0000;
  assign bus.busy      = (state != IDLE);

endmodule
